nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit add/subtract unit built around one 4-bit carry-lookahead

---
 rtl/nibble_serial_adder_pkg.sv | 21 ++
 rtl/nibble_serial_adder_cla4_slice.sv | 40 ++++
 rtl/nibble_serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder_pkg
//  Brief    : Shared definitions for the nibble-serial add/subtract unit:
//             FSM state encodings and the slice width.
//  Revision : 1.0  initial release
// ============================================================================
package nibble_serial_adder_pkg;

    // Width of the carry-lookahead slice reused on every pass
    localparam int NIB = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_cla4_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla4_slice
//  Brief    : Combinational 4-bit carry-lookahead adder. The carry into bit 3
//             is exposed so the caller can derive signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] sum,
    output logic           cout,
    output logic           c3
);

    logic [NIB-1:0] w_g;
    logic [NIB-1:0] w_p;
    logic [NIB-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries, each expanded directly from the slice inputs
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum = w_p ^ w_c;
    assign c3  = w_c[3];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Brief    : WIDTH-bit add/subtract computed one nibble per cycle, LSB first,
//             through a single 4-bit CLA slice with the carry registered
//             between passes. Valid/ready handshake on input and output.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / NIB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [NIB-1:0]   w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_c3;

    // The only adder hardware: always works on the low nibble of the shifters
    cla4_slice u_slice (
        .a    (r_opa[NIB-1:0]),
        .b    (r_opb[NIB-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout),
        .c3   (w_slice_c3)
    );

    // Sequencer: accept operands, run N slice passes, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B and force carry-in
                        r_opa   <= a;
                        r_opb   <= op_sub ? ~b : b;
                        r_carry <= op_sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result nibbles enter at the top so the first one ends at the bottom
                    r_sum   <= {w_slice_sum, r_sum[WIDTH-1:NIB]};
                    r_opa   <= {{NIB{1'b0}}, r_opa[WIDTH-1:NIB]};
                    r_opb   <= {{NIB{1'b0}}, r_opb[WIDTH-1:NIB]};
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        // Final pass handles the MSB, so its carries define cout/ovf
                        r_cout      <= w_slice_cout;
                        r_ovf       <= w_slice_c3 ^ w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
